// File: rtl/h14tx_pkt_assembler.sv
// HDMI 1.4 data-island packet assembler: header/subpacket BCH parity and 9-bit TERC4 payload per cycle.
// Optional shadow capture of header/sub at cnt=0 is enabled with H14TX_PKT_ASM_LATCH_EN.
module h14tx_pkt_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_island_period,
  input  logic [23:0] header,
  input  logic [55:0] sub [3:0],
  output logic [8:0]  packet_data,
  output logic        packet_req
);

  logic [4:0]  cnt;
  logic [7:0]  ecc_h;
  logic [7:0]  ecc_s [3:0];
  logic [23:0] hdr_eff;
  logic [55:0] sub_eff [3:0];

  logic        hdr_bit;
  logic [3:0]  even_bits;
  logic [3:0]  odd_bits;
  logic [7:0]  ecc_h_nxt;
  logic [7:0]  ecc_s_nxt [3:0];

  function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic b);
    logic fb;
    fb = ecc[0] ^ b;
    return {1'b0, ecc[7:1]} ^ (fb ? 8'h83 : 8'h00);
  endfunction

`ifdef H14TX_PKT_ASM_LATCH_EN
  logic [23:0] hdr_shadow;
  logic [55:0] sub_shadow [3:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdr_shadow <= '0;
      for (int k = 0; k < 4; k++) sub_shadow[k] <= '0;
    end else if (data_island_period && cnt == 5'd0) begin
      hdr_shadow <= header;
      for (int k = 0; k < 4; k++) sub_shadow[k] <= sub[k];
    end
  end

  // cnt=0 has no shadow yet, so the first bit comes straight from the inputs.
  always_comb begin
    hdr_eff = (cnt == 5'd0) ? header : hdr_shadow;
    for (int k = 0; k < 4; k++) sub_eff[k] = (cnt == 5'd0) ? sub[k] : sub_shadow[k];
  end
`else
  always_comb begin
    hdr_eff = header;
    for (int k = 0; k < 4; k++) sub_eff[k] = sub[k];
  end
`endif

  always_comb begin
    hdr_bit   = 1'b0;
    ecc_h_nxt = ecc_h;
    if (cnt < 5'd24) begin
      hdr_bit   = hdr_eff[cnt];
      ecc_h_nxt = bch_step(ecc_h, hdr_eff[cnt]);
    end else begin
      hdr_bit = ecc_h[cnt[2:0]];
    end

    even_bits = '0;
    odd_bits  = '0;
    for (int k = 0; k < 4; k++) begin
      ecc_s_nxt[k] = ecc_s[k];
      if (cnt < 5'd28) begin
        even_bits[k] = sub_eff[k][{cnt, 1'b0}];
        odd_bits[k]  = sub_eff[k][{cnt, 1'b1}];
        ecc_s_nxt[k] = bch_step(bch_step(ecc_s[k], sub_eff[k][{cnt, 1'b0}]),
                                sub_eff[k][{cnt, 1'b1}]);
      end else begin
        // cnt 28..31 maps onto parity bit pairs 0..3 via the low counter bits.
        even_bits[k] = ecc_s[k][{cnt[1:0], 1'b0}];
        odd_bits[k]  = ecc_s[k][{cnt[1:0], 1'b1}];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !data_island_period) begin
      cnt         <= 5'd0;
      ecc_h       <= 8'h00;
      packet_data <= 9'h000;
      for (int k = 0; k < 4; k++) ecc_s[k] <= 8'h00;
    end else begin
      cnt         <= cnt + 5'd1;
      packet_data <= {odd_bits, even_bits, hdr_bit};
      if (cnt == 5'd31) begin
        ecc_h <= 8'h00;
        for (int k = 0; k < 4; k++) ecc_s[k] <= 8'h00;
      end else begin
        ecc_h <= ecc_h_nxt;
        for (int k = 0; k < 4; k++) ecc_s[k] <= ecc_s_nxt[k];
      end
    end
  end

  assign packet_req = data_island_period && (cnt == 5'd31);

endmodule
